multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control state machine for the multicycle MIPS datapath. It sequences every instruction through fetch, decode, execute, memory and writeback, and drives all datapath enables and mux selects. It generates the 2-bit `ALUOp` consumed by `ALUControl_Block` and waits on a memory-ready handshake with a bounded timeout.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum number of wait cycles in any memory state before a fault; legal range 1–15; the counter is 4 bits.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `Opcode` in 6: `IR[31:26]`, valid from DECODE onward.
- `Zero` in 1: ALU zero flag, used in BRANCH.
- `MemReady` in 1: memory has completed the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA` out 1 each: datapath controls.
- `ALUSrcB` out 2: ALU B-input select. 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- `ALUOp` out 2: to `ALUControl_Block`. 00 = add, 01 = sub, 10 = decode by funct, 11 = logical op (`ALUControl` 01).
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `IllegalOp` out 1: one-cycle pulse on an unknown opcode.
- `MemFault` out 1: one-cycle pulse on a memory timeout.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, IMMEX, IMMWB, JUMP.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, andi 001100, j 000010.
- Outputs are decoded from state (Moore). The only exceptions are the FETCH/MEMRD/MEMWR completion strobes described below.
- IDLE: all outputs 0; next state is FETCH.
- FETCH:
  - Drives `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00.
  - `IRWrite` and `PCWrite` assert only in the cycle `MemReady`=1; the state advances to DECODE on that cycle.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00 (branch target precompute). Next state by opcode:
  - lw/sw → MEMADR
  - R → EXEC
  - beq → BRANCH
  - addi/andi → IMMEX
  - j → JUMP
  - any other opcode → pulse `IllegalOp`, go to FETCH
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: `MemRead`=1, `IorD`=1. Advances to MEMWB on `MemReady`.
- MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0. Next state FETCH.
- MEMWR: `MemWrite`=1, `IorD`=1. Advances to FETCH on `MemReady`.
- EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Next state ALUWB.
- ALUWB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0. Next state FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01. Next state FETCH. The datapath forms `PC enable = PCWrite | (PCWriteCond & Zero)`.
- IMMEX: `ALUSrcA`=1, `ALUSrcB`=10. `ALUOp`=00 for addi, 11 for andi. Next state IMMWB.
- IMMWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0. Next state FETCH.
- JUMP: `PCWrite`=1, `PCSource`=10. Next state FETCH.
- Wait counter (FETCH, MEMRD, MEMWR only):
  - Cleared on entry to each of these states.
  - Increments each cycle that `MemReady`=0.
  - If `MemReady`=0 while the counter equals `MEM_TIMEOUT`, pulse `MemFault` and go to FETCH.
  - A fault in FETCH retries fetch with the PC unchanged. A fault in MEMRD/MEMWR abandons the instruction: no `RegWrite`, and a new fetch starts.
- `MemReady`=1 in the timeout cycle counts as success; no fault is raised.
- `MemReady` is ignored outside the memory states.

## Timing
- `reset`=1 at any edge, including mid-instruction or mid-wait: next state is IDLE, the counter clears, and all outputs are 0 in the following cycle. Memory access is dropped with no write strobe.
- With zero-wait memory (`MemReady` held 1), cycles per instruction: lw 5, sw 4, R 4, addi/andi 4, beq 3, j 3. Each memory wait cycle adds 1.
- First FETCH occurs 1 cycle after `reset` deasserts, in the IDLE→FETCH sequence.
- `IllegalOp` and `MemFault` are high for exactly one cycle, in the same cycle as the transition to FETCH.
- `Opcode` is sampled in DECODE (and in MEMADR/IMMEX) only; it is assumed stable because the IR is only written in FETCH.

## Structure
- Shared include `mips_defs.vh` holds the opcode localparams, the `ALUOp` and `PCSource` encodings, and the state encodings (4-bit). `ALUControl_Block` and this block use the same `ALUOp` constants.
- Sub-module `control_outputs`: purely combinational state(+opcode, `MemReady`)→control decode. The parent holds the state register, the wait counter and the next-state logic.

## Test plan
- Reset mid-MEMRD with `MemReady`=0 → next cycle state IDLE, all outputs 0. FETCH follows 1 cycle after release.
- R-type opcode 000000, `MemReady`=1 always → 4 cycles; `ALUOp`=10 in EXEC; `RegWrite`=1 and `RegDst`=1 in ALUWB only.
- lw with 3 wait cycles in MEMRD → `MemRead`/`IorD` held high for 4 cycles, then MEMWB with `MemtoReg`=1. Total 8 cycles.
- beq with `Zero`=1 and again with `Zero`=0 → `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01 for one cycle in both cases. `PCWrite` stays 0 in BRANCH.
- `MEM_TIMEOUT`=3, MEMWR with `MemReady` stuck at 0 → `MemFault` pulses on the 4th cycle in MEMWR, next state FETCH, no `RegWrite`. Repeat with `MemReady`=1 on that 4th cycle → no fault.
- Opcode 111111 in DECODE → `IllegalOp` pulses 1 cycle, next state FETCH. andi opcode 001100 → `ALUOp`=11 in IMMEX.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg
// Shared definitions for the multicycle MIPS control path: FSM state
// encoding (4-bit), opcodes, ALUOp / ALUSrcB / PCSource encodings (the same
// ALUOp constants feed ALUControl_Block), and the decoded control bundle.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_IMMEX, S_IMMWB, S_JUMP
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       mem_fault;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_J};
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if
// Controller <-> datapath bundle.
//   master (controller): reads Opcode, Zero, MemReady; drives all controls.
//   slave  (datapath)  : the reverse.
interface multicycle_control_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       IllegalOp, MemFault;

    modport master (
        input  Opcode, Zero, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               IllegalOp, MemFault
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               IllegalOp, MemFault
    );
endinterface

// File: rtl/multicycle_control_outputs.sv
// multicycle_control_outputs
// Purely combinational control decode.
//   state     : current FSM state
//   opcode    : IR[31:26]
//   mem_ready : memory completed its access this cycle
//   at_limit  : wait counter has reached MEM_TIMEOUT
//   ctrl      : decoded datapath controls and fault pulses
module multicycle_control_outputs
    import multicycle_control_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       at_limit,
    output ctrl_t      ctrl
);
    // Timeout fires only when the access is still outstanding at the limit;
    // a ready in the limit cycle wins.
    logic timed_out;
    assign timed_out = !mem_ready && at_limit;

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUB_FOUR;
                // IR and PC+4 commit only on the cycle the fetch completes
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.mem_fault = timed_out;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = ALUB_IMM_SL2;
                ctrl.illegal_op = !is_legal_op(opcode);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_fault = timed_out;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_fault = timed_out;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_IMMEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = (opcode == OP_ANDI) ? ALUOP_LOGIC : ALUOP_ADD;
            end
            S_IMMWB: ctrl.reg_write = 1'b1;
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Main FSM of the multicycle MIPS datapath.
//   clk, reset : clock, synchronous active-high reset
//   bus        : master side of multicycle_control_if (Opcode/Zero/MemReady
//                in, all datapath enables, selects and fault pulses out)
// MEM_TIMEOUT (1..15) bounds the wait cycles in FETCH/MEMRD/MEMWR.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_control_if.master bus
);
    state_t     state;
    logic [3:0] wait_cnt;
    logic       at_limit;
    ctrl_t      ctrl;

    assign at_limit = (wait_cnt == 4'(MEM_TIMEOUT));

    // The counter defaults to zero every cycle and only counts while a
    // memory state is stalled, so it is naturally clear on entry to any
    // memory state (including a FETCH retry after a fault).
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= '0;
            unique case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (bus.MemReady)  state <= S_DECODE;
                    else if (at_limit) state <= S_FETCH;
                    else               wait_cnt <= wait_cnt + 4'd1;
                end
                S_DECODE: begin
                    unique case (bus.Opcode)
                        OP_LW, OP_SW:     state <= S_MEMADR;
                        OP_R:             state <= S_EXEC;
                        OP_BEQ:           state <= S_BRANCH;
                        OP_ADDI, OP_ANDI: state <= S_IMMEX;
                        OP_J:             state <= S_JUMP;
                        default:          state <= S_FETCH;
                    endcase
                end
                S_MEMADR: state <= (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD: begin
                    if (bus.MemReady)  state <= S_MEMWB;
                    else if (at_limit) state <= S_FETCH;
                    else               wait_cnt <= wait_cnt + 4'd1;
                end
                S_MEMWR: begin
                    if (bus.MemReady || at_limit) state <= S_FETCH;
                    else                          wait_cnt <= wait_cnt + 4'd1;
                end
                S_EXEC:  state <= S_ALUWB;
                S_IMMEX: state <= S_IMMWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP: state <= S_FETCH;
                default: state <= S_IDLE;
            endcase
        end
    end

    multicycle_control_outputs u_outputs (
        .state     (state),
        .opcode    (bus.Opcode),
        .mem_ready (bus.MemReady),
        .at_limit  (at_limit),
        .ctrl      (ctrl)
    );

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.i_or_d;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.IllegalOp   = ctrl.illegal_op;
    assign bus.MemFault    = ctrl.mem_fault;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Directed cycle-by-cycle check of every control output against values
// taken from the control table, with MEM_TIMEOUT = 3.
module tb_multicycle_control;
    localparam int TMO = 3;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if bus();
    multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [17:0] v;
    } exp_t;
    exp_t sbq[$];

    int n_pass = 0;
    int n_total = 0;

    logic [17:0] obs;
    assign obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                  bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                  bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                  bus.PCSource, bus.IllegalOp, bus.MemFault};

    function automatic logic [17:0] cv(
        input logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa,
        input logic [1:0] asb, aop, pcs,
        input logic ill, flt);
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa,
                asb, aop, pcs, ill, flt};
    endfunction

    localparam logic [17:0] IDLE = '0;
    function automatic logic [17:0] e_fetch(input logic r, input logic f);
        return cv(r,0,0,1,0,r,0,0,0,0, 2'b01,2'b00,2'b00, 0,f);
    endfunction
    function automatic logic [17:0] e_decode(input logic ill);
        return cv(0,0,0,0,0,0,0,0,0,0, 2'b11,2'b00,2'b00, ill,0);
    endfunction
    function automatic logic [17:0] e_memadr();
        return cv(0,0,0,0,0,0,0,0,0,1, 2'b10,2'b00,2'b00, 0,0);
    endfunction
    function automatic logic [17:0] e_memrd(input logic f);
        return cv(0,0,1,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,f);
    endfunction
    function automatic logic [17:0] e_memwb();
        return cv(0,0,0,0,0,0,1,0,1,0, 2'b00,2'b00,2'b00, 0,0);
    endfunction
    function automatic logic [17:0] e_memwr(input logic f);
        return cv(0,0,1,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,f);
    endfunction
    function automatic logic [17:0] e_exec();
        return cv(0,0,0,0,0,0,0,0,0,1, 2'b00,2'b10,2'b00, 0,0);
    endfunction
    function automatic logic [17:0] e_aluwb();
        return cv(0,0,0,0,0,0,0,1,1,0, 2'b00,2'b00,2'b00, 0,0);
    endfunction
    function automatic logic [17:0] e_branch();
        return cv(0,1,0,0,0,0,0,0,0,1, 2'b00,2'b01,2'b01, 0,0);
    endfunction
    function automatic logic [17:0] e_immex(input logic andi);
        return cv(0,0,0,0,0,0,0,0,0,1, 2'b10, andi ? 2'b11 : 2'b00, 2'b00, 0,0);
    endfunction
    function automatic logic [17:0] e_immwb();
        return cv(0,0,0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b00, 0,0);
    endfunction
    function automatic logic [17:0] e_jump();
        return cv(1,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b10, 0,0);
    endfunction

    // One clock cycle: drive MemReady, queue the expectation, compare on
    // the falling edge, then step past the next rising edge.
    task automatic cyc(input string tag, input logic rdy, input logic [17:0] e);
        exp_t x;
        bus.MemReady = rdy;
        x.tag = tag;
        x.v   = e;
        sbq.push_back(x);
        @(negedge clk);
        x = sbq.pop_front();
        n_total++;
        assert (obs === x.v) n_pass++;
        else $error("FAIL %s: observed %b expected %b", x.tag, obs, x.v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.Opcode   = OP_R;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset_idle", 1, IDLE);
        reset = 1'b0;
        cyc("release_idle", 1, IDLE);

        // R-type, MemReady ignored outside memory states
        bus.Opcode = OP_R;
        cyc("r_fetch", 1, e_fetch(1, 0));
        cyc("r_decode", 0, e_decode(0));
        cyc("r_exec", 0, e_exec());
        cyc("r_aluwb", 1, e_aluwb());

        // lw with 3 wait cycles in MEMRD
        bus.Opcode = OP_LW;
        cyc("lw_fetch", 1, e_fetch(1, 0));
        cyc("lw_decode", 1, e_decode(0));
        cyc("lw_memadr", 1, e_memadr());
        for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", 0, e_memrd(0));
        cyc("lw_memrd_done", 1, e_memrd(0));
        cyc("lw_memwb", 1, e_memwb());

        // sw zero-wait
        bus.Opcode = OP_SW;
        cyc("sw_fetch", 1, e_fetch(1, 0));
        cyc("sw_decode", 1, e_decode(0));
        cyc("sw_memadr", 1, e_memadr());
        cyc("sw_memwr", 1, e_memwr(0));

        // beq taken and not taken: identical control either way
        bus.Opcode = OP_BEQ;
        bus.Zero = 1'b1;
        cyc("beq1_fetch", 1, e_fetch(1, 0));
        cyc("beq1_decode", 1, e_decode(0));
        cyc("beq1_branch", 1, e_branch());
        bus.Zero = 1'b0;
        cyc("beq0_fetch", 1, e_fetch(1, 0));
        cyc("beq0_decode", 1, e_decode(0));
        cyc("beq0_branch", 1, e_branch());

        // addi / andi
        bus.Opcode = OP_ADDI;
        cyc("addi_fetch", 1, e_fetch(1, 0));
        cyc("addi_decode", 1, e_decode(0));
        cyc("addi_immex", 1, e_immex(0));
        cyc("addi_immwb", 1, e_immwb());
        bus.Opcode = OP_ANDI;
        cyc("andi_fetch", 1, e_fetch(1, 0));
        cyc("andi_decode", 1, e_decode(0));
        cyc("andi_immex", 1, e_immex(1));
        cyc("andi_immwb", 1, e_immwb());

        // j
        bus.Opcode = OP_J;
        cyc("j_fetch", 1, e_fetch(1, 0));
        cyc("j_decode", 1, e_decode(0));
        cyc("j_jump", 1, e_jump());

        // illegal opcode: pulse then straight back to FETCH
        bus.Opcode = OP_BAD;
        cyc("ill_fetch", 1, e_fetch(1, 0));
        cyc("ill_decode", 1, e_decode(1));
        bus.Opcode = OP_J;
        cyc("ill_refetch", 1, e_fetch(1, 0));
        cyc("ill_j_decode", 1, e_decode(0));
        cyc("ill_j_jump", 1, e_jump());

        // sw timeout: fault on the 4th MEMWR cycle, no RegWrite, then FETCH
        bus.Opcode = OP_SW;
        cyc("swto_fetch", 1, e_fetch(1, 0));
        cyc("swto_decode", 1, e_decode(0));
        cyc("swto_memadr", 1, e_memadr());
        for (int i = 0; i < TMO; i++) cyc("swto_wait", 0, e_memwr(0));
        cyc("swto_fault", 0, e_memwr(1));
        cyc("swto_refetch", 1, e_fetch(1, 0));
        cyc("swto2_decode", 1, e_decode(0));
        cyc("swto2_memadr", 1, e_memadr());
        // ready in the limit cycle is a success
        for (int i = 0; i < TMO; i++) cyc("swok_wait", 0, e_memwr(0));
        cyc("swok_limit_ready", 1, e_memwr(0));

        // fetch timeout: retry fetch, then a normal j
        bus.Opcode = OP_J;
        for (int i = 0; i < TMO; i++) cyc("fto_wait", 0, e_fetch(0, 0));
        cyc("fto_fault", 0, e_fetch(0, 1));
        cyc("fto_retry", 1, e_fetch(1, 0));
        cyc("fto_decode", 1, e_decode(0));
        cyc("fto_jump", 1, e_jump());

        // lw timeout in MEMRD abandons the load (no MEMWB)
        bus.Opcode = OP_LW;
        cyc("lwto_fetch", 1, e_fetch(1, 0));
        cyc("lwto_decode", 1, e_decode(0));
        cyc("lwto_memadr", 1, e_memadr());
        for (int i = 0; i < TMO; i++) cyc("lwto_wait", 0, e_memrd(0));
        cyc("lwto_fault", 0, e_memrd(1));
        cyc("lwto_refetch", 1, e_fetch(1, 0));
        cyc("lwto2_decode", 1, e_decode(0));
        cyc("lwto2_memadr", 1, e_memadr());

        // reset mid-MEMRD wait
        cyc("rst_memrd_wait", 0, e_memrd(0));
        reset = 1'b1;
        cyc("rst_memrd_edge", 0, e_memrd(0));
        reset = 1'b0;
        cyc("rst_mid_idle", 0, IDLE);
        // counter restarted: full wait budget available again
        for (int i = 0; i < TMO; i++) cyc("rst_fetch_wait", 0, e_fetch(0, 0));
        cyc("rst_fetch_ok", 1, e_fetch(1, 0));
        cyc("rst_decode", 1, e_decode(0));

        n_total++;
        assert (sbq.size() == 0) n_pass++;
        else $error("FAIL scoreboard_drain: observed %0d expected 0", sbq.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
